// File: rtl/adc_sched_pkg.sv
// Shared constants and state encodings for the ADC read-port scheduler.
package adc_sched_pkg;

  localparam int ADC_CHANNELS = 8;
  localparam int CHAN_W       = 3;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_ADDR   = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_EMIT   = 2'd3
  } scan_state_t;

  typedef enum logic [1:0] {
    HP_IDLE = 2'd0,
    HP_RD   = 2'd1,
    HP_ACK  = 2'd2
  } host_phase_t;

endpackage

// File: rtl/adc_poll_sched_rr_next_chan.sv
// Circular search for the next enabled channel after i_cur; i_cur itself is
// checked last, so a single enabled channel is revisited.
module rr_next_chan
  import adc_sched_pkg::*;
(
  input  logic [ADC_CHANNELS-1:0] i_mask,
  input  logic [CHAN_W-1:0]       i_cur,
  output logic                    o_found,
  output logic [CHAN_W-1:0]       o_next
);

  logic [CHAN_W-1:0] w_idx;

  // First enabled channel in order cur+1, cur+2, ..., cur
  always_comb begin
    o_found = 1'b0;
    o_next  = i_cur;
    w_idx   = i_cur;
    for (int i = 1; i <= ADC_CHANNELS; i++) begin
      w_idx   = i_cur + CHAN_W'(i);
      o_next  = (!o_found && i_mask[w_idx]) ? w_idx : o_next;
      o_found = o_found | i_mask[w_idx];
    end
  end

endmodule

// File: rtl/adc_poll_sched.sv
// Shares the ADC sample-bank read port between a round-robin hysteresis
// scanner (change events) and a host req/ack single-channel reader.
module adc_poll_sched
  import adc_sched_pkg::*;
#(
  parameter int ADC_WIDTH = 8,
  parameter int HYST      = 2,
  parameter int SCAN_DIV  = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  output logic [CHAN_W-1:0]       adc_addr,
  input  logic [ADC_WIDTH-1:0]    adc_q,
  input  logic [ADC_CHANNELS-1:0] chan_en,
  input  logic                    host_req,
  input  logic [CHAN_W-1:0]       host_chan,
  output logic                    host_ack,
  output logic [ADC_WIDTH-1:0]    host_data,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic [CHAN_W-1:0]       evt_chan,
  output logic [ADC_WIDTH-1:0]    evt_value
);

  localparam int                 DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0]   DIV_LOAD = DIV_W'(SCAN_DIV - 1);
  localparam logic [ADC_WIDTH:0] HYST_V   = (ADC_WIDTH + 1)'(HYST);

  scan_state_t r_sstate, w_sstate_nxt;
  host_phase_t r_hphase, w_hphase_nxt;

  logic [DIV_W-1:0]        r_div;
  logic [CHAN_W-1:0]       r_scan_ch;
  logic [ADC_WIDTH-1:0]    r_last [ADC_CHANNELS];
  logic [ADC_CHANNELS-1:0] r_seen;
  logic [CHAN_W-1:0]       r_adc_addr;
  logic                    r_host_ack;
  logic [ADC_WIDTH-1:0]    r_host_data;
  logic                    r_evt_valid;
  logic [CHAN_W-1:0]       r_evt_chan;
  logic [ADC_WIDTH-1:0]    r_evt_value;

  logic                    w_host_gnt;
  logic                    w_scan_gnt;
  logic                    w_decide;
  logic                    w_found;
  logic [CHAN_W-1:0]       w_next_ch;
  logic [ADC_WIDTH:0]      w_diff;
  logic                    w_emit;
  logic                    w_accept;

  // Magnitude of a-b, one bit wider so 0x00 vs 0xFF does not wrap
  function automatic logic [ADC_WIDTH:0] abs_diff(input logic [ADC_WIDTH-1:0] a,
                                                  input logic [ADC_WIDTH-1:0] b);
    if (a >= b) begin
      abs_diff = {1'b0, a} - {1'b0, b};
    end else begin
      abs_diff = {1'b0, b} - {1'b0, a};
    end
  endfunction

  rr_next_chan u_rr (
    .i_mask  (chan_en),
    .i_cur   (r_scan_ch),
    .o_found (w_found),
    .o_next  (w_next_ch)
  );

  // Host wins a tie; the host only competes while idle
  assign w_host_gnt = (r_hphase == HP_IDLE) && host_req;
  assign w_scan_gnt = (r_sstate == ST_ADDR) && !w_host_gnt;
  assign w_decide   = (r_sstate == ST_WAIT) && (r_div == DIV_W'(0));
  assign w_diff     = abs_diff(adc_q, r_last[r_scan_ch]);
  assign w_emit     = !r_seen[r_scan_ch] || (w_diff >= HYST_V);
  assign w_accept   = (r_sstate == ST_EMIT) && evt_ready;

  // State registers for scanner and host phase
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sstate <= ST_WAIT;
      r_hphase <= HP_IDLE;
    end else begin
      r_sstate <= w_sstate_nxt;
      r_hphase <= w_hphase_nxt;
    end
  end

  // Scanner next state
  always_comb begin
    w_sstate_nxt = r_sstate;
    case (r_sstate)
      ST_WAIT: begin
        if (w_decide && w_found) begin
          w_sstate_nxt = ST_ADDR;
        end else begin
          w_sstate_nxt = ST_WAIT;
        end
      end
      ST_ADDR: begin
        if (w_scan_gnt) begin
          w_sstate_nxt = ST_SAMPLE;
        end else begin
          w_sstate_nxt = ST_ADDR;
        end
      end
      ST_SAMPLE: begin
        if (w_emit) begin
          w_sstate_nxt = ST_EMIT;
        end else begin
          w_sstate_nxt = ST_WAIT;
        end
      end
      ST_EMIT: begin
        if (evt_ready) begin
          w_sstate_nxt = ST_WAIT;
        end else begin
          w_sstate_nxt = ST_EMIT;
        end
      end
      default: w_sstate_nxt = ST_WAIT;
    endcase
  end

  // Host phase next state: grant -> RD (sample) -> ACK -> IDLE
  always_comb begin
    w_hphase_nxt = r_hphase;
    case (r_hphase)
      HP_IDLE: begin
        if (w_host_gnt) begin
          w_hphase_nxt = HP_RD;
        end else begin
          w_hphase_nxt = HP_IDLE;
        end
      end
      HP_RD:   w_hphase_nxt = HP_ACK;
      HP_ACK:  w_hphase_nxt = HP_IDLE;
      default: w_hphase_nxt = HP_IDLE;
    endcase
  end

  // Read port address and host return path
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_adc_addr  <= {CHAN_W{1'b0}};
      r_host_ack  <= 1'b0;
      r_host_data <= {ADC_WIDTH{1'b0}};
    end else begin
      if (w_host_gnt) begin
        r_adc_addr <= host_chan;
      end else if (w_scan_gnt) begin
        r_adc_addr <= r_scan_ch;
      end else begin
        r_adc_addr <= r_adc_addr;
      end
      r_host_ack <= (r_hphase == HP_RD);
      if (r_hphase == HP_RD) begin
        r_host_data <= adc_q;
      end else begin
        r_host_data <= r_host_data;
      end
    end
  end

  // Scanner datapath: divider, channel pointer, event latch, reported history
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div       <= DIV_LOAD;
      r_scan_ch   <= CHAN_W'(ADC_CHANNELS - 1);
      r_evt_valid <= 1'b0;
      r_evt_chan  <= {CHAN_W{1'b0}};
      r_evt_value <= {ADC_WIDTH{1'b0}};
      r_seen      <= {ADC_CHANNELS{1'b0}};
      for (int i = 0; i < ADC_CHANNELS; i++) begin
        r_last[i] <= {ADC_WIDTH{1'b0}};
      end
    end else begin
      if ((r_sstate == ST_WAIT) && !w_decide) begin
        r_div <= r_div - DIV_W'(1);
      end else begin
        r_div <= DIV_LOAD;
      end
      if (w_decide && w_found) begin
        r_scan_ch <= w_next_ch;
      end else begin
        r_scan_ch <= r_scan_ch;
      end
      if ((r_sstate == ST_SAMPLE) && w_emit) begin
        r_evt_valid <= 1'b1;
        r_evt_chan  <= r_scan_ch;
        r_evt_value <= adc_q;
      end else if (w_accept) begin
        r_evt_valid          <= 1'b0;
        r_last[r_evt_chan]   <= r_evt_value;
        r_seen[r_evt_chan]   <= 1'b1;
      end else begin
        r_evt_valid <= r_evt_valid;
      end
    end
  end

  assign adc_addr  = r_adc_addr;
  assign host_ack  = r_host_ack;
  assign host_data = r_host_data;
  assign evt_valid = r_evt_valid;
  assign evt_chan  = r_evt_chan;
  assign evt_value = r_evt_value;

endmodule

// File: tb/tb_adc_poll_sched.sv
// Directed bench for adc_poll_sched with a behavioural sample bank.
module tb_adc_poll_sched;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] adc_addr;
  logic [7:0] adc_q;
  logic [7:0] chan_en = 8'h00;
  logic       host_req = 1'b0;
  logic [2:0] host_chan = 3'd0;
  logic       host_ack;
  logic [7:0] host_data;
  logic       evt_valid;
  logic       evt_ready = 1'b0;
  logic [2:0] evt_chan;
  logic [7:0] evt_value;

  logic [7:0] mem [8];
  int total = 0;
  int bad = 0;

  assign adc_q = mem[adc_addr];

  always #5 clk = ~clk;

  adc_poll_sched #(.ADC_WIDTH(8), .HYST(2), .SCAN_DIV(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .adc_addr  (adc_addr),
    .adc_q     (adc_q),
    .chan_en   (chan_en),
    .host_req  (host_req),
    .host_chan (host_chan),
    .host_ack  (host_ack),
    .host_data (host_data),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_chan  (evt_chan),
    .evt_value (evt_value)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_evt(input int budget, output bit got, output int n);
    got = 1'b0;
    n = 0;
    while (!got && n < budget) begin
      tick();
      n++;
      if (evt_valid === 1'b1) got = 1'b1;
    end
  endtask

  task automatic accept();
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
  endtask

  task automatic test_reset();
    bit got;
    int n;
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    mem[0] = 8'h40;
    chan_en = 8'h01;
    reset_n = 1'b0;
    tick();
    tick();
    total++;
    if ({adc_addr, host_ack, host_data, evt_valid, evt_chan, evt_value} !== 31'd0)
      begin bad++; $display("FAIL reset_outputs: addr=%0d ack=%b data=%h valid=%b chan=%0d value=%h, required all 0",
                            adc_addr, host_ack, host_data, evt_valid, evt_chan, evt_value); end
    reset_n = 1'b1;
    wait_evt(40, got, n);
    total++;
    if (!got || n != 18) begin bad++; $display("FAIL first_event_latency: got=%b cycles=%0d, required got=1 cycles=18", got, n); end
    total++;
    if (evt_chan !== 3'd0 || evt_value !== 8'h40) begin bad++; $display("FAIL first_event_data: chan=%0d value=%h, required chan=0 value=40", evt_chan, evt_value); end
    accept();
    total++;
    if (evt_valid !== 1'b0) begin bad++; $display("FAIL accept_clears_valid: valid=%b, required 0", evt_valid); end
    wait_evt(60, got, n);
    total++;
    if (got) begin bad++; $display("FAIL unchanged_no_event: got event chan=%0d value=%h, required none", evt_chan, evt_value); accept(); end
  endtask

  task automatic test_hyst();
    logic [7:0] vals [7];
    bit         expv [7];
    bit got;
    int n;
    vals = '{8'h41, 8'h42, 8'h3F, 8'h00, 8'hFF, 8'hFE, 8'h01};
    expv = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      mem[0] = vals[i];
      wait_evt(40, got, n);
      total++;
      if (got !== expv[i]) begin bad++; $display("FAIL hyst_decision[%0d]: value=%h event=%b, required event=%b", i, vals[i], got, expv[i]); end
      if (got) begin
        total++;
        if (evt_chan !== 3'd0 || evt_value !== vals[i]) begin bad++; $display("FAIL hyst_value[%0d]: chan=%0d value=%h, required chan=0 value=%h", i, evt_chan, evt_value, vals[i]); end
        accept();
      end
    end
  endtask

  task automatic test_host_collide();
    bit got;
    int n;
    mem[0] = 8'h20;
    wait_evt(40, got, n);
    total++;
    if (!got) begin bad++; $display("FAIL collide_setup_event: got=0, required 1"); end
    accept();
    mem[0] = 8'h60;
    mem[5] = 8'h9A;
    repeat (16) tick();
    host_chan = 3'd5;
    host_req = 1'b1;
    tick();
    total++;
    if (adc_addr !== 3'd5 || host_ack !== 1'b0) begin bad++; $display("FAIL collide_host_addr: addr=%0d ack=%b, required addr=5 ack=0", adc_addr, host_ack); end
    tick();
    total++;
    if (host_ack !== 1'b1 || host_data !== 8'h9A || adc_addr !== 3'd0)
      begin bad++; $display("FAIL collide_ack: ack=%b data=%h addr=%0d, required ack=1 data=9a addr=0", host_ack, host_data, adc_addr); end
    host_req = 1'b0;
    tick();
    total++;
    if (evt_valid !== 1'b1 || evt_value !== 8'h60 || host_ack !== 1'b0 || host_data !== 8'h9A)
      begin bad++; $display("FAIL collide_scanner_after: valid=%b value=%h ack=%b data=%h, required valid=1 value=60 ack=0 data=9a",
                            evt_valid, evt_value, host_ack, host_data); end
    accept();
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_ch;
    int nevt;
    int nack;
    int last_ack;
    for (int i = 1; i < 8; i++) mem[i] = 8'(8'h11 * i);
    mem[0] = 8'h50;
    chan_en = 8'hFF;
    evt_ready = 1'b1;
    host_chan = 3'd3;
    host_req = 1'b1;
    exp_ch = 3'd1;
    nevt = 0;
    nack = 0;
    last_ack = -1;
    for (int cyc = 0; cyc < 400 && nevt < 8; cyc++) begin
      tick();
      if (host_ack === 1'b1) begin
        if (last_ack >= 0) begin
          total++;
          if (cyc - last_ack != 3 || host_data !== 8'h33) begin bad++; $display("FAIL b2b_ack: gap=%0d data=%h, required gap=3 data=33", cyc - last_ack, host_data); end
        end
        last_ack = cyc;
        nack++;
      end
      if (evt_valid === 1'b1) begin
        total++;
        if (evt_chan !== exp_ch || evt_value !== mem[exp_ch]) begin bad++; $display("FAIL b2b_event_order: chan=%0d value=%h, required chan=%0d value=%h", evt_chan, evt_value, exp_ch, mem[exp_ch]); end
        exp_ch = exp_ch + 3'd1;
        nevt++;
      end
    end
    host_req = 1'b0;
    tick();
    evt_ready = 1'b0;
    repeat (3) tick();
    total++;
    if (nevt != 8) begin bad++; $display("FAIL b2b_event_count: events=%0d, required 8", nevt); end
    total++;
    if (nack < 10) begin bad++; $display("FAIL b2b_ack_count: acks=%0d, required at least 10", nack); end
  endtask

  task automatic test_chan_mask();
    bit reached;
    bit moved;
    bit evt_seen;
    logic [2:0] prev;
    logic [2:0] seq [3];
    int k;
    chan_en = 8'h04;
    reached = 1'b0;
    for (int i = 0; i < 60 && !reached; i++) begin
      tick();
      if (adc_addr === 3'd2) reached = 1'b1;
    end
    total++;
    if (!reached) begin bad++; $display("FAIL mask_visit_ch2: addr=%0d, required 2 within 60 cycles", adc_addr); end
    chan_en = 8'h00;
    moved = 1'b0;
    evt_seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (adc_addr !== 3'd2) moved = 1'b1;
      if (evt_valid !== 1'b0) evt_seen = 1'b1;
    end
    total++;
    if (moved || evt_seen) begin bad++; $display("FAIL mask_none_idle: addr_moved=%b event=%b, required 0 0", moved, evt_seen); end
    chan_en = 8'h84;
    prev = adc_addr;
    k = 0;
    for (int i = 0; i < 120 && k < 3; i++) begin
      tick();
      if (adc_addr !== prev) begin
        seq[k] = adc_addr;
        k++;
        prev = adc_addr;
      end
      if (evt_valid !== 1'b0) evt_seen = 1'b1;
    end
    total++;
    if (k != 3 || seq[0] !== 3'd7 || seq[1] !== 3'd2 || seq[2] !== 3'd7 || evt_seen)
      begin bad++; $display("FAIL mask_order: visits=%0d seq=%0d,%0d,%0d event=%b, required 3 visits 7,2,7 event=0",
                            k, seq[0], seq[1], seq[2], evt_seen); end
  endtask

  task automatic test_reset_mid();
    bit got;
    int n;
    chan_en = 8'h01;
    mem[0] = 8'h01;
    evt_ready = 1'b0;
    wait_evt(60, got, n);
    total++;
    if (!got || evt_value !== 8'h01) begin bad++; $display("FAIL stall_setup: got=%b value=%h, required got=1 value=01", got, evt_value); end
    repeat (3) tick();
    total++;
    if (evt_valid !== 1'b1 || evt_value !== 8'h01) begin bad++; $display("FAIL stall_hold: valid=%b value=%h, required valid=1 value=01", evt_valid, evt_value); end
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (evt_valid !== 1'b0 || evt_value !== 8'h00 || adc_addr !== 3'd0)
      begin bad++; $display("FAIL async_reset: valid=%b value=%h addr=%0d, required 0 00 0", evt_valid, evt_value, adc_addr); end
    tick();
    reset_n = 1'b1;
    wait_evt(40, got, n);
    total++;
    if (!got || n != 18 || evt_chan !== 3'd0 || evt_value !== 8'h01)
      begin bad++; $display("FAIL reemit_after_reset: got=%b cycles=%0d chan=%0d value=%h, required 1 18 0 01", got, n, evt_chan, evt_value); end
    accept();
  endtask

  initial begin
    #1;
    test_reset();
    test_hyst();
    test_host_collide();
    test_back_to_back();
    test_chan_mask();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
